// File: rtl/process_relocator.sv
// rtl/process_relocator.sv - process table, context-switch FSM and load/store immediate relocation
module process_relocator #(
  parameter int IMM_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int NPROC     = 4,
  parameter int PID_W     = 2,
  parameter int DATA_BIAS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cfg_we,
  input  logic [PID_W-1:0]  i_cfg_pid,
  input  logic [ADDR_W-1:0] i_Read_Data1,
  input  logic [ADDR_W-1:0] i_Read_Data2,
  input  logic [IMM_W-1:0]  i_cfg_limit,
  input  logic              i_interruptionProcess,
  input  logic [PID_W-1:0]  i_switch_pid,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [IMM_W-1:0]  i_instruction_imm,
  input  logic              i_fault_clear,
  output logic [IMM_W-1:0]  o_immediate,
  output logic [ADDR_W-1:0] o_Base_addr,
  output logic [PID_W-1:0]  o_cur_pid,
  output logic              o_switch_busy,
  output logic              o_switch_done,
  output logic              o_fault,
  output logic [1:0]        o_fault_code
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t r_state, w_next;

  logic              r_valid [NPROC];
  logic [ADDR_W-1:0] r_base  [NPROC];
  logic [ADDR_W-1:0] r_mem   [NPROC];
  logic [IMM_W-1:0]  r_limit [NPROC];

  logic [ADDR_W-1:0] r_act_base, r_act_mem;
  logic [IMM_W-1:0]  r_act_limit;
  logic [PID_W-1:0]  r_cur_pid, r_sw_pid;
  logic [IMM_W-1:0]  r_imm;
  logic              r_fault;
  logic [1:0]        r_fault_code;

  logic              w_sel_valid;
  logic [ADDR_W-1:0] w_sel_base, w_sel_mem;
  logic [IMM_W-1:0]  w_sel_limit;
  logic              w_reloc, w_bounds, w_load_ok, w_pid_fault;
  logic [1:0]        w_new_fault;
  logic              w_unused_mem;

  // A captured pid at or beyond NPROC matches no entry and so reads as invalid.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_base  = '0;
    w_sel_mem   = '0;
    w_sel_limit = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (r_sw_pid == PID_W'(i)) begin
        w_sel_valid = r_valid[i];
        w_sel_base  = r_base[i];
        w_sel_mem   = r_mem[i];
        w_sel_limit = r_limit[i];
      end
    end
  end

  assign w_reloc      = (i_MemRead | i_MemWrite) && (r_state == S_IDLE);
  assign w_bounds     = w_reloc && (r_act_limit != '0) && (i_instruction_imm >= r_act_limit);
  assign w_load_ok    = (r_state == S_LOAD) && w_sel_valid;
  assign w_pid_fault  = (r_state == S_LOAD) && !w_sel_valid;
  assign w_new_fault  = {w_pid_fault, w_bounds};
  assign w_unused_mem = ^r_act_mem;

  always_comb begin
    w_next        = r_state;
    o_switch_busy = (r_state != S_IDLE);
    o_switch_done = 1'b0;
    case (r_state)
      S_IDLE: if (i_interruptionProcess) w_next = S_LOAD;
      S_LOAD: w_next = w_load_ok ? S_DONE : S_IDLE;
      S_DONE: begin
        o_switch_done = 1'b1;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Table writes land at the same edge the request is captured, so LOAD sees them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NPROC; i++) begin
        r_valid[i] <= (i == 0);
        r_base[i]  <= '0;
        r_mem[i]   <= '0;
        r_limit[i] <= '0;
      end
      r_sw_pid <= '0;
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        if (i_cfg_we && (i_cfg_pid == PID_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_base[i]  <= i_Read_Data1;
          r_mem[i]   <= i_Read_Data2 + ADDR_W'(DATA_BIAS);
          r_limit[i] <= i_cfg_limit;
        end
      end
      if ((r_state == S_IDLE) && i_interruptionProcess) r_sw_pid <= i_switch_pid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_act_base  <= '0;
      r_act_mem   <= '0;
      r_act_limit <= '0;
      r_cur_pid   <= '0;
    end else if (w_load_ok) begin
      r_act_base  <= w_sel_base;
      r_act_mem   <= w_sel_mem;
      r_act_limit <= w_sel_limit;
      r_cur_pid   <= r_sw_pid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_imm        <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      r_imm <= w_reloc ? (i_instruction_imm + r_act_mem[IMM_W-1:0]) : i_instruction_imm;
      if (w_new_fault != 2'b00) begin
        r_fault      <= 1'b1;
        r_fault_code <= (i_fault_clear ? 2'b00 : r_fault_code) | w_new_fault;
      end else if (i_fault_clear) begin
        r_fault      <= 1'b0;
        r_fault_code <= 2'b00;
      end
    end
  end

  assign o_immediate  = r_imm;
  assign o_Base_addr  = r_act_base;
  assign o_cur_pid    = r_cur_pid;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_process_relocator.sv
// tb/tb_process_relocator.sv - scoreboard bench for process_relocator against a behavioural model
module tb_process_relocator;

  logic        clk = 1'b0;
  logic        reset, cfg_we, intr, mem_rd, mem_wr, fclr;
  logic [1:0]  cfg_pid, sw_pid;
  logic [31:0] rd1, rd2;
  logic [15:0] cfg_lim, imm;
  logic [15:0] d_imm;
  logic [31:0] d_base;
  logic [1:0]  d_pid, d_code;
  logic        d_busy, d_done, d_fault;

  always #5 clk = ~clk;

  process_relocator dut (
    .i_clk(clk), .i_reset(reset), .i_cfg_we(cfg_we), .i_cfg_pid(cfg_pid),
    .i_Read_Data1(rd1), .i_Read_Data2(rd2), .i_cfg_limit(cfg_lim),
    .i_interruptionProcess(intr), .i_switch_pid(sw_pid),
    .i_MemRead(mem_rd), .i_MemWrite(mem_wr), .i_instruction_imm(imm),
    .i_fault_clear(fclr),
    .o_immediate(d_imm), .o_Base_addr(d_base), .o_cur_pid(d_pid),
    .o_switch_busy(d_busy), .o_switch_done(d_done), .o_fault(d_fault),
    .o_fault_code(d_code)
  );

  typedef struct packed {
    logic [15:0] imm;
    logic [31:0] base;
    logic [1:0]  pid;
    logic        busy, done, fault;
    logic [1:0]  code;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: process table, active context and a switch-in-progress tracker.
  logic        m_valid [4];
  logic [31:0] m_base  [4];
  logic [31:0] m_mem   [4];
  logic [15:0] m_lim   [4];
  logic [31:0] a_base, a_mem;
  logic [15:0] a_lim, m_imm;
  logic [1:0]  a_pid, tgt, m_code;
  int          since_req;

  task automatic model_step();
    logic [1:0] nf;
    exp_t e;
    nf = 2'b00;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = (i == 0); m_base[i] = 0; m_mem[i] = 0; m_lim[i] = 0;
      end
      a_base = 0; a_mem = 0; a_lim = 0; a_pid = 0; m_imm = 0; m_code = 0;
      since_req = -1;
    end else begin
      if ((mem_rd || mem_wr) && since_req < 0) begin
        m_imm = imm + a_mem[15:0];
        if (a_lim != 0 && imm >= a_lim) nf[0] = 1'b1;
      end else begin
        m_imm = imm;
      end
      if (since_req < 0) begin
        if (intr) begin tgt = sw_pid; since_req = 0; end
      end else if (since_req == 0) begin
        if (m_valid[tgt]) begin
          a_base = m_base[tgt]; a_mem = m_mem[tgt]; a_lim = m_lim[tgt]; a_pid = tgt;
          since_req = 1;
        end else begin
          nf[1] = 1'b1; since_req = -1;
        end
      end else begin
        since_req = -1;
      end
      if (cfg_we) begin
        m_valid[cfg_pid] = 1'b1; m_base[cfg_pid] = rd1;
        m_mem[cfg_pid] = rd2 + 32'd16; m_lim[cfg_pid] = cfg_lim;
      end
      if (nf != 0)   m_code = (fclr ? 2'b00 : m_code) | nf;
      else if (fclr) m_code = 2'b00;
    end
    e.imm = m_imm; e.base = a_base; e.pid = a_pid;
    e.busy = (since_req >= 0); e.done = (since_req == 1);
    e.fault = (m_code != 0); e.code = m_code;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("immediate", 32'(d_imm), 32'(e.imm));
        chk("base_addr", d_base, e.base);
        chk("cur_pid", 32'(d_pid), 32'(e.pid));
        chk("switch_busy", 32'(d_busy), 32'(e.busy));
        chk("switch_done", 32'(d_done), 32'(e.done));
        chk("fault", 32'(d_fault), 32'(e.fault));
        chk("fault_code", 32'(d_code), 32'(e.code));
      end
    end
  end

  task automatic idle_in();
    reset = 0; cfg_we = 0; cfg_pid = 0; rd1 = 0; rd2 = 0; cfg_lim = 0;
    intr = 0; sw_pid = 0; mem_rd = 0; mem_wr = 0; imm = 0; fclr = 0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    @(negedge clk);
    idle_in(); reset = 1; step();
    reset = 1; step();
    mem_rd = 1; imm = 16'h0004; step();
    cfg_we = 1; cfg_pid = 1; rd1 = 32'h400; rd2 = 32'h100; cfg_lim = 16'h40; step();
    intr = 1; sw_pid = 1; step();
    step(); step();
    mem_wr = 1; imm = 16'h0008; step();
    mem_rd = 1; imm = 16'h0040; step();
    mem_rd = 1; imm = 16'h003F; step();
    fclr = 1; step();
    intr = 1; sw_pid = 2; step();
    step(); step();
    fclr = 1; mem_rd = 1; imm = 16'h0041; step();
    fclr = 1; step();
    cfg_we = 1; cfg_pid = 3; rd1 = 32'h800; rd2 = 32'h0000FFE8; cfg_lim = 0; step();
    intr = 1; sw_pid = 3; step();
    intr = 1; sw_pid = 0; mem_rd = 1; imm = 16'h0010; step();
    intr = 1; sw_pid = 0; mem_wr = 1; imm = 16'h0010; step();
    mem_rd = 1; mem_wr = 1; imm = 16'h0010; step();
    intr = 1; sw_pid = 1; cfg_we = 1; cfg_pid = 1; rd1 = 32'h900; rd2 = 32'h20; cfg_lim = 16'h8; step();
    reset = 1; step();
    step(); step();
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_pid = 2'($urandom_range(0, 3));
      rd1     = $urandom;
      rd2     = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
      cfg_lim = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 512));
      intr    = ($urandom_range(0, 7) == 0);
      sw_pid  = 2'($urandom_range(0, 3));
      mem_rd  = ($urandom_range(0, 1) == 0);
      mem_wr  = ($urandom_range(0, 2) == 0);
      imm     = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 600)) : 16'($urandom);
      fclr    = ($urandom_range(0, 15) == 0);
      step();
    end
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/process_relocator.md
PROCESS_RELOCATOR -- requirements
Module: process_relocator

Interface
REQ-001 Parameter IMM_W, default 16, width of instruction immediate and relocated immediate.
REQ-002 Parameter ADDR_W, default 32, width of base/data-region words.
REQ-003 Parameter NPROC, default 4, number of process table entries.
REQ-004 Parameter PID_W, default 2, process id width; NPROC SHALL be <= 2**PID_W.
REQ-005 Parameter DATA_BIAS, default 16, constant added to data-region start on table write.
REQ-006 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cfg_we  in  1  write process table entry cfg_pid this cycle.
REQ-009 cfg_pid  in  PID_W  table entry index for write.
REQ-010 Read_Data1  in  ADDR_W  code base for entry being written.
REQ-011 Read_Data2  in  ADDR_W  data region start for entry being written.
REQ-012 cfg_limit  in  IMM_W  data region size in bytes; 0 = unbounded.
REQ-013 interruptionProcess  in  1  context switch request, sampled one cycle.
REQ-014 switch_pid  in  PID_W  target process of switch, sampled with interruptionProcess.
REQ-015 MemRead, MemWrite  in  1 each  current instruction is a load/store.
REQ-016 instruction_imm  in  IMM_W  raw immediate of current instruction.
REQ-017 fault_clear  in  1  clears fault and fault_code.
REQ-018 immediate  out  IMM_W  registered relocated immediate.
REQ-019 Base_addr  out  ADDR_W  code base of active process.
REQ-020 cur_pid  out  PID_W  active process id.
REQ-021 switch_busy  out  1  high while switch FSM not IDLE.
REQ-022 switch_done  out  1  one-cycle pulse on successful switch.
REQ-023 fault  out  1  sticky fault flag; fault_code out 2: bit0 bounds violation, bit1 invalid-pid switch.

Function
REQ-024 Table: NPROC entries {valid, base[ADDR_W], mem_addr[ADDR_W], limit[IMM_W]}; cfg_we writes valid=1, base=Read_Data1, mem_addr=Read_Data2+DATA_BIAS (mod 2**ADDR_W), limit=cfg_limit; cfg_pid >= NPROC write ignored.
REQ-025 Active registers {Base_addr, act_mem, act_limit, cur_pid} change only on switch completion or reset; table writes to the active pid do not affect them until next switch.
REQ-026 FSM states IDLE, LOAD, DONE; IDLE->LOAD when interruptionProcess=1, capturing switch_pid.
REQ-027 LOAD: reads captured entry (includes writes made in request cycle); valid and pid < NPROC -> copy into active regs, go DONE; else set fault, fault_code[1], active regs unchanged, go IDLE.
REQ-028 DONE: switch_done=1 for exactly this cycle, go IDLE; switch latency request->done = 2 cycles.
REQ-029 interruptionProcess while switch_busy=1 SHALL be ignored.
REQ-030 Relocation, 1-cycle latency: if MemRead|MemWrite and state IDLE, immediate <= (instruction_imm + act_mem[IMM_W-1:0]) mod 2**IMM_W; otherwise immediate <= instruction_imm.
REQ-031 MemRead and MemWrite both high SHALL be treated as one memory op.
REQ-032 Bounds: memory op in IDLE with act_limit != 0 and instruction_imm (unsigned) >= act_limit sets fault and fault_code[0]; relocated value is still output.
REQ-033 Memory op during LOAD/DONE passes instruction_imm unrelocated, no bounds check.
REQ-034 fault_code bits accumulate (OR) until fault_clear; fault_clear and new fault in same cycle -> new fault wins.

Reset
REQ-035 On reset: entry 0 valid with base=0, mem_addr=0, limit=0; entries 1..NPROC-1 invalid and zero.
REQ-036 On reset: Base_addr=0, cur_pid=0, act_mem=0, act_limit=0, immediate=0, fault=0, fault_code=0, switch_done=0, FSM IDLE.
REQ-037 Reset during LOAD/DONE aborts switch; no switch_done pulse; reset has priority over all inputs.

Verification
REQ-038 Reset, MemRead=1, instruction_imm=0x0004 -> next cycle immediate=0x0004, fault=0.
REQ-039 cfg_we pid1 Read_Data1=0x400, Read_Data2=0x100, limit=0x40; switch to 1 -> switch_done at +2, Base_addr=0x400, cur_pid=1; MemWrite imm=0x8 -> immediate=0x118.
REQ-040 Active pid1 limit 0x40, MemRead imm=0x40 -> fault=1, fault_code=01, immediate=0x150; fault_clear -> fault=0.
REQ-041 Switch to invalid pid2 -> no switch_done, fault_code=10, cur_pid unchanged.
REQ-042 mem_addr=0xFFF8, imm=0x0010 -> immediate=0x0008 (wrap); second request during busy ignored.
REQ-043 Reset asserted in LOAD -> next cycle IDLE, cur_pid=0, switch_done never pulses.
